regfile_param: RTL and testbench

- Parametrised integer register file; next generation of the single-cycle CPU's two-read/one-write register file.
- Generalised in data width, register count and read-port count.
- Adds hardwired-zero register 0, asynchronous reset to known contents, and a per-register busy scoreboard for pipeline hazard detection.
- Sits in ID stage: decode reads operands and busy flags; WB writes results; issue reserves destinations.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_scoreboard.sv | 41 ++++
 rtl/regfile_param.sv | 73 +++++++
 tb/tb_regfile_param.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the parametrised integer register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);
  localparam int REG_ZERO  = 0;

  typedef logic [AW_DEF-1:0]   reg_idx_t;
  typedef logic [XLEN_DEF-1:0] xword_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: flush beats write-back, and allocation beats
// write-back when both target the same register.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_idx_i,
  input  logic             alloc_en_i,
  input  logic [AW-1:0]    alloc_idx_i,
  input  logic             flush_i,
  output logic [NREGS-1:0] busy_o
);

  logic [NREGS-1:0] busy_q, busy_d;

  // NOTE: start from the held value so every path assigns busy_d; no latch.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (wr_en_i && (wr_idx_i != AW'(REG_ZERO))) busy_d[wr_idx_i] = 1'b0;
      if (alloc_en_i && (alloc_idx_i != AW'(REG_ZERO))) busy_d[alloc_idx_i] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  // NOTE: non-blocking assignment for flops so all state updates on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised multi-read-port register file with hardwired zero register and
// busy scoreboard. Define REGFILE_BYPASS_EN for same-cycle write-through reads.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int             XLEN    = XLEN_DEF,
  parameter int             NREGS   = NREGS_DEF,
  parameter int             NRP     = 2,
  parameter int             RST_IDX = 5,
  parameter logic [XLEN-1:0] RST_VAL = XLEN'(4),
  localparam int            AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                RegWrite,
  input  logic [AW-1:0]       wr,
  input  logic [XLEN-1:0]     wd,
  input  logic [NRP*AW-1:0]   rr,
  output logic [NRP*XLEN-1:0] rd,
  output logic [NRP-1:0]      rd_busy,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_reg,
  input  logic                flush,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            we;

  // Register 0 is never written, so its reset value of zero is permanent.
  assign we = RegWrite && (wr != AW'(REG_ZERO));

  // NOTE: the storage array is reset deliberately, since software relies on
  // known contents after reset; this rules out a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= ((RST_IDX != 0) && (i == RST_IDX)) ? RST_VAL : '0;
    end else if (we) begin
      regs_q[wr] <= wd;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (RegWrite),
    .wr_idx_i    (wr),
    .alloc_en_i  (alloc_en),
    .alloc_idx_i (alloc_reg),
    .flush_i     (flush),
    .busy_o      (busy_vec)
  );

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [AW-1:0] idx;
    assign idx = rr[p*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit                 = we && (idx == wr);
    assign rd[p*XLEN +: XLEN]  = hit ? wd : regs_q[idx];
    assign rd_busy[p]          = hit ? (alloc_en && !flush && (alloc_reg == wr))
                                     : busy_vec[idx];
`else
    assign rd[p*XLEN +: XLEN]  = regs_q[idx];
    assign rd_busy[p]          = busy_vec[idx];
`endif
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: a default instance and a 64-bit,
// 16-entry, 3-port instance, each against an array model of the register file.
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        a_we, a_alloc_en, a_flush;
  logic [4:0]  a_wr, a_alloc_reg;
  logic [31:0] a_wd;
  logic [9:0]  a_rr;
  logic [63:0] a_rd;
  logic [1:0]  a_rd_busy;
  logic [31:0] a_busy_vec;

  regfile_param dut_a (
    .clk(clk), .rst_n(rst_n), .RegWrite(a_we), .wr(a_wr), .wd(a_wd),
    .rr(a_rr), .rd(a_rd), .rd_busy(a_rd_busy), .alloc_en(a_alloc_en),
    .alloc_reg(a_alloc_reg), .flush(a_flush), .busy_vec(a_busy_vec)
  );

  // Instance B: wide, small, three read ports, all-zero reset
  logic         b_we;
  logic [3:0]   b_wr;
  logic [63:0]  b_wd;
  logic [11:0]  b_rr;
  logic [191:0] b_rd;
  logic [2:0]   b_rd_busy;
  logic [15:0]  b_busy_vec;
  logic         b_alloc_en, b_flush;
  logic [3:0]   b_alloc_reg;

  regfile_param #(.XLEN(64), .NREGS(16), .NRP(3), .RST_IDX(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .RegWrite(b_we), .wr(b_wr), .wd(b_wd),
    .rr(b_rr), .rd(b_rd), .rd_busy(b_rd_busy), .alloc_en(b_alloc_en),
    .alloc_reg(b_alloc_reg), .flush(b_flush), .busy_vec(b_busy_vec)
  );

  int errors = 0;
  int checks = 0;
  bit model_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: register contents and busy set
  logic [31:0] ma_reg [32];
  bit          ma_busy [32];
  logic [63:0] mb_reg [16];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin ma_reg[i] = 32'd0; ma_busy[i] = 1'b0; end
      ma_reg[5] = 32'd4;
      for (int i = 0; i < 16; i++) mb_reg[i] = 64'd0;
    end else begin
      if (a_we && a_wr != 5'd0) ma_reg[a_wr] = a_wd;
      if (a_flush) begin
        for (int i = 0; i < 32; i++) ma_busy[i] = 1'b0;
      end else begin
        if (a_we && a_wr != 5'd0) ma_busy[a_wr] = 1'b0;
        if (a_alloc_en && a_alloc_reg != 5'd0) ma_busy[a_alloc_reg] = 1'b1;
      end
      if (b_we && b_wr != 4'd0) mb_reg[b_wr] = b_wd;
    end
  end

  function automatic logic [31:0] a_exp_rd(input int p);
    logic [4:0] idx = a_rr[p*5 +: 5];
    if (BYP && a_we && a_wr != 5'd0 && a_wr == idx) return a_wd;
    return (idx == 5'd0) ? 32'd0 : ma_reg[idx];
  endfunction

  function automatic logic a_exp_busy(input int p);
    logic [4:0] idx = a_rr[p*5 +: 5];
    if (BYP && a_we && a_wr != 5'd0 && a_wr == idx)
      return a_alloc_en && !a_flush && (a_alloc_reg == a_wr);
    return ma_busy[idx];
  endfunction

  function automatic logic [31:0] a_exp_vec();
    logic [31:0] v = '0;
    for (int i = 1; i < 32; i++) v[i] = ma_busy[i];
    return v;
  endfunction

  function automatic logic [63:0] b_exp_rd(input int p);
    logic [3:0] idx = b_rr[p*4 +: 4];
    if (BYP && b_we && b_wr != 4'd0 && b_wr == idx) return b_wd;
    return (idx == 4'd0) ? 64'd0 : mb_reg[idx];
  endfunction

  // Every-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    if (model_on) begin
      for (int p = 0; p < 2; p++) begin
        check($sformatf("a_rd%0d", p), {32'd0, a_rd[p*32 +: 32]}, {32'd0, a_exp_rd(p)});
        check($sformatf("a_rd_busy%0d", p), {63'd0, a_rd_busy[p]}, {63'd0, a_exp_busy(p)});
      end
      check("a_busy_vec", {32'd0, a_busy_vec}, {32'd0, a_exp_vec()});
      for (int p = 0; p < 3; p++)
        check($sformatf("b_rd%0d", p), b_rd[p*64 +: 64], b_exp_rd(p));
      check("b_rd_busy", {61'd0, b_rd_busy}, 64'd0);
      check("b_busy_vec", {48'd0, b_busy_vec}, 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_we = 1'b0; a_wr = '0; a_wd = '0;
    a_alloc_en = 1'b0; a_alloc_reg = '0; a_flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a_idle();
    a_rr = {5'd3, 5'd5};
    b_we = 1'b0; b_wr = '0; b_wd = '0; b_rr = {4'd15, 4'd5, 4'd0};
    b_alloc_en = 1'b0; b_alloc_reg = '0; b_flush = 1'b0;
    tick();
    model_on = 1'b1;

    // Reset contents
    check("rst_rd5", {32'd0, a_rd[31:0]}, 64'd4);
    check("rst_rd3", {32'd0, a_rd[63:32]}, 64'd0);
    check("rst_busy_vec", {32'd0, a_busy_vec}, 64'd0);
    check("b_rst_rd5", b_rd[127:64], 64'd0);
    #2 rst_n = 1'b1;
    tick();

    // Zero register ignores write and alloc
    a_we = 1'b1; a_wr = 5'd0; a_wd = 32'hDEADBEEF;
    a_alloc_en = 1'b1; a_alloc_reg = 5'd0; a_rr = {5'd0, 5'd0};
    tick();
    a_idle();
    #1 check("zero_rd", {32'd0, a_rd[31:0]}, 64'd0);
    check("zero_busy", {63'd0, a_busy_vec[0]}, 64'd0);

    // Write / read of register 7
    a_we = 1'b1; a_wr = 5'd7; a_wd = 32'h12345678; a_rr = {5'd5, 5'd7};
    #1 check("wr7_same_cycle", {32'd0, a_rd[31:0]}, BYP ? 64'h12345678 : 64'd0);
    tick();
    a_idle();
    #1 check("wr7_after", {32'd0, a_rd[31:0]}, 64'h12345678);
    check("rd5_unchanged", {32'd0, a_rd[63:32]}, 64'd4);
    tick();

    // Scoreboard on register 9
    a_alloc_en = 1'b1; a_alloc_reg = 5'd9; a_rr = {5'd0, 5'd9};
    tick();
    a_idle();
    #1 check("alloc9_busy", {63'd0, a_rd_busy[0]}, 64'd1);
    check("alloc9_vec", {32'd0, a_busy_vec}, 64'h200);
    tick();
    a_we = 1'b1; a_wr = 5'd9; a_wd = 32'h0000AAAA;
    #1 check("wb9_same_cycle_busy", {63'd0, a_rd_busy[0]}, BYP ? 64'd0 : 64'd1);
    tick();
    a_idle();
    #1 check("wb9_busy_clear", {32'd0, a_busy_vec}, 64'd0);
    check("wb9_data", {32'd0, a_rd[31:0]}, 64'h0000AAAA);
    a_we = 1'b1; a_wr = 5'd9; a_wd = 32'h0000BBBB;
    a_alloc_en = 1'b1; a_alloc_reg = 5'd9;
    #1 check("alloc_wb9_same_cycle", {63'd0, a_rd_busy[0]}, BYP ? 64'd1 : 64'd0);
    tick();
    a_idle();
    #1 check("alloc_wins", {32'd0, a_busy_vec}, 64'h200);

    // Flush with simultaneous alloc and write
    for (int r = 3; r <= 6; r++) begin
      if (r != 5) begin
        a_alloc_en = 1'b1; a_alloc_reg = 5'(r);
        tick();
      end
    end
    a_idle();
    #1 check("pre_flush_vec", {32'd0, a_busy_vec}, 64'h258);
    a_flush = 1'b1; a_alloc_en = 1'b1; a_alloc_reg = 5'd8;
    a_we = 1'b1; a_wr = 5'd10; a_wd = 32'h77; a_rr = {5'd7, 5'd10};
    tick();
    a_idle();
    #1 check("flush_vec", {32'd0, a_busy_vec}, 64'd0);
    check("flush_wr_data", {32'd0, a_rd[31:0]}, 64'h77);

    // Two ports on the same index
    a_rr = {5'd7, 5'd7};
    #1 check("same_idx_p0", {32'd0, a_rd[31:0]}, 64'h12345678);
    check("same_idx_p1", {32'd0, a_rd[63:32]}, 64'h12345678);
    tick();

    // Wide instance: all three ports read register 15
    b_we = 1'b1; b_wr = 4'd15; b_wd = 64'hFFFF_0000_FFFF_0000;
    tick();
    b_we = 1'b0; b_rr = {4'd15, 4'd15, 4'd15};
    #1 check("b_p0", b_rd[63:0], 64'hFFFF_0000_FFFF_0000);
    check("b_p1", b_rd[127:64], 64'hFFFF_0000_FFFF_0000);
    check("b_p2", b_rd[191:128], 64'hFFFF_0000_FFFF_0000);
    tick();

    // Mid-cycle reset overrides pending write and alloc
    a_alloc_en = 1'b1; a_alloc_reg = 5'd12;
    tick();
    a_we = 1'b1; a_wr = 5'd7; a_wd = 32'hFFFF; a_alloc_reg = 5'd13; a_rr = {5'd3, 5'd5};
    #1 check("pre_rst_vec", {32'd0, a_busy_vec}, 64'h1000);
    rst_n = 1'b0;
    #1 check("async_rst_rd5", {32'd0, a_rd[31:0]}, 64'd4);
    check("async_rst_rd3", {32'd0, a_rd[63:32]}, 64'd0);
    check("async_rst_vec", {32'd0, a_busy_vec}, 64'd0);
    check("async_rst_b15", b_rd[191:128], 64'd0);
    tick();
    a_idle();
    a_rr = {5'd7, 5'd7};
    rst_n = 1'b1;
    #1 check("rst_wr7_cleared", {32'd0, a_rd[31:0]}, 64'd0);
    check("rst_no_alloc", {32'd0, a_busy_vec}, 64'd0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
